// File: rtl/and_qual_n_pkg.sv
// Shared definitions for the and_qual_n family.
//   MODE_LEVEL / MODE_PULSE : output behaviour selectors
//   chan_state_e            : per-channel qualification state
//   clog2()                 : ceiling log2, used to size the run counter
`timescale 100ps/10ps
package and_qual_n_pkg;

  localparam int unsigned MODE_LEVEL = 0;
  localparam int unsigned MODE_PULSE = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_QUALIFIED
  } chan_state_e;

  // Ceiling log2 with a floor of 1 so a counter is never zero bits wide.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (longint unsigned p = 1; p < longint'(v); p = p << 1) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/and_qual_chan.sv
// One qualified AND channel: bubbled AND term, sampling flop, saturating run
// counter and registered output bit.
//   clk, rst_n : clock (rising edge) and async active-low clear
//   ce         : clock enable; low holds every register
//   strobes    : WIDTH raw inputs for this channel
//   o          : registered qualified output
//   o_next_c   : combinational next value of o (feeds the shared ANY register)
`timescale 100ps/10ps
module and_qual_chan
  import and_qual_n_pkg::*;
#(
  parameter int unsigned          WIDTH    = 5,
  parameter logic [WIDTH-1:0]     INV_MASK = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int unsigned          QUAL     = 1,
  parameter int unsigned          MODE     = MODE_LEVEL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] strobes,
  output logic             o,
  output logic             o_next_c
);

  localparam int unsigned     CNT_W   = clog2(QUAL + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(QUAL);
  localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(QUAL - 1);

  generate
    if (QUAL < 1) begin : g_bad_qual
      $error("and_qual_chan: QUAL must be at least 1");
    end
    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
      $error("and_qual_chan: WIDTH must be within 2..16");
    end
    if (MODE > MODE_PULSE) begin : g_bad_mode
      $error("and_qual_chan: MODE must be 0 or 1");
    end
  endgenerate

  logic             term_c;
  logic             t_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  chan_state_e      state;
  chan_state_e      state_next;

  // Bubbled AND term.
  always_comb begin
    term_c = &(strobes ^ INV_MASK);
  end

  // State, counter, sample and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q   <= 1'b0;
      cnt   <= '0;
      state <= ST_IDLE;
      o     <= 1'b0;
    end else if (ce) begin
      t_q   <= term_c;
      cnt   <= cnt_next;
      state <= state_next;
      o     <= o_next_c;
    end
  end

  // Next-state: any false sample restarts; counter saturates at QUAL.
  always_comb begin
    cnt_next   = cnt;
    state_next = state;
    o_next_c   = 1'b0;

    if (!t_q) begin
      cnt_next   = '0;
      state_next = ST_IDLE;
    end else if (cnt != CNT_MAX) begin
      cnt_next   = cnt + CNT_W'(1);
      state_next = (cnt_next == CNT_MAX) ? ST_QUALIFIED : ST_COUNT;
    end

    // Pulse fires only on the increment into QUAL, so it cannot repeat
    // until a false sample has cleared the counter.
    if (MODE == MODE_PULSE) begin
      o_next_c = t_q && (cnt == CNT_ARM);
    end else begin
      o_next_c = (state_next == ST_QUALIFIED);
    end
  end

endmodule

// File: rtl/and_qual_n.sv
// Multi-channel qualified AND with per-input bubbles.
//   C    : clock, rising edge
//   CLRN : asynchronous clear, active-low
//   CE   : clock enable; low holds all state
//   I    : CHANNELS*WIDTH inputs, channel k at [k*WIDTH +: WIDTH]
//   O    : registered qualified output per channel
//   ANY  : registered OR of the next-state of O
`timescale 100ps/10ps
module and_qual_n
  import and_qual_n_pkg::*;
#(
  parameter int unsigned      CHANNELS = 1,
  parameter int unsigned      WIDTH    = 5,
  parameter logic [WIDTH-1:0] INV_MASK = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int unsigned      QUAL     = 1,
  parameter int unsigned      MODE     = MODE_LEVEL
) (
  input  logic                      C,
  input  logic                      CLRN,
  input  logic                      CE,
  input  logic [CHANNELS*WIDTH-1:0] I,
  output logic [CHANNELS-1:0]       O,
  output logic                      ANY
);

  generate
    if (CHANNELS < 1) begin : g_bad_channels
      $error("and_qual_n: CHANNELS must be at least 1");
    end
  endgenerate

  logic [CHANNELS-1:0] o_next_c;

  // Independent channels.
  for (genvar k = 0; k < int'(CHANNELS); k++) begin : g_chan
    and_qual_chan #(
      .WIDTH    (WIDTH),
      .INV_MASK (INV_MASK),
      .QUAL     (QUAL),
      .MODE     (MODE)
    ) u_chan (
      .clk      (C),
      .rst_n    (CLRN),
      .ce       (CE),
      .strobes  (I[k*WIDTH +: WIDTH]),
      .o        (O[k]),
      .o_next_c (o_next_c[k])
    );
  end

  // ANY is built from next-state so it lands on the same edge as O.
  always_ff @(posedge C or negedge CLRN) begin
    if (!CLRN) begin
      ANY <= 1'b0;
    end else if (CE) begin
      ANY <= |o_next_c;
    end
  end

endmodule

// File: tb/tb_and_qual_n.sv
// Self-checking bench for and_qual_n across five parameter configurations.
`timescale 100ps/10ps
module tb_and_qual_n;

  logic        clk;
  logic [4:0]  clrn;
  logic [4:0]  ce;
  logic [4:0]  i0, i1, i2, i3;
  logic [11:0] i4;
  logic        o0, o1, o2, o3;
  logic [2:0]  o4;
  logic        any0, any1, any2, any3, any4;

  int total;
  int bad;

  typedef struct {
    int         dut;
    logic [3:0] val;
    string      tag;
  } exp_t;

  exp_t sb[$];

  // Defaults: level, QUAL=1, mask 00001.
  and_qual_n u0 (.C(clk), .CLRN(clrn[0]), .CE(ce[0]), .I(i0), .O(o0), .ANY(any0));

  and_qual_n #(.QUAL(4)) u1 (
    .C(clk), .CLRN(clrn[1]), .CE(ce[1]), .I(i1), .O(o1), .ANY(any1));

  and_qual_n #(.QUAL(3)) u2 (
    .C(clk), .CLRN(clrn[2]), .CE(ce[2]), .I(i2), .O(o2), .ANY(any2));

  and_qual_n #(.QUAL(2), .MODE(1)) u3 (
    .C(clk), .CLRN(clrn[3]), .CE(ce[3]), .I(i3), .O(o3), .ANY(any3));

  and_qual_n #(.CHANNELS(3), .WIDTH(4), .INV_MASK(4'b0101), .QUAL(2)) u4 (
    .C(clk), .CLRN(clrn[4]), .CE(ce[4]), .I(i4), .O(o4), .ANY(any4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // {ANY, O[2:0]} of the selected instance.
  function automatic logic [3:0] obs(input int dut);
    case (dut)
      0:       return {any0, 2'b00, o0};
      1:       return {any1, 2'b00, o1};
      2:       return {any2, 2'b00, o2};
      3:       return {any3, 2'b00, o3};
      default: return {any4, o4};
    endcase
  endfunction

  // Drive one cycle of stimulus, queue the expectation, compare after the edge.
  task automatic cyc(input int dut, input logic [11:0] iv, input logic cev,
                     input logic [3:0] ev, input string tag);
    exp_t e;
    case (dut)
      0:       i0 = iv[4:0];
      1:       i1 = iv[4:0];
      2:       i2 = iv[4:0];
      3:       i3 = iv[4:0];
      default: i4 = iv;
    endcase
    ce[dut] = cev;
    e.dut = dut;
    e.val = ev;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(e.tag, obs(e.dut), e.val);
  endtask

  localparam logic [11:0] T5  = 12'b0000_0001_1110;  // term true, 5-wide mask 00001
  localparam logic [11:0] F5  = 12'b0000_0001_1111;  // term false
  localparam logic [11:0] Z5  = 12'b0;                // term false

  initial begin
    total = 0;
    bad   = 0;
    clrn  = '0;
    ce    = '1;
    i0 = 5'b11110;
    i1 = 5'b11110;
    i2 = '0;
    i3 = '0;
    i4 = '0;

    // Reset with terms true: nothing asserts.
    for (int n = 0; n < 2; n++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rst_u0_%0d", n), obs(0), 4'b0000);
      chk($sformatf("rst_u1_%0d", n), obs(1), 4'b0000);
    end
    i1   = '0;
    clrn = '1;

    // Defaults: O after edge 2, drops two edges after the term goes false.
    cyc(0, T5, 1'b1, 4'b0000, "dflt_e1");
    cyc(0, T5, 1'b1, 4'b1001, "dflt_e2");
    cyc(0, T5, 1'b1, 4'b1001, "dflt_e3");
    cyc(0, F5, 1'b1, 4'b1001, "dflt_off1");
    cyc(0, F5, 1'b1, 4'b0000, "dflt_off2");

    // QUAL=4: clear mid-count at cnt=2, then requalify in 5 edges.
    for (int n = 1; n <= 3; n++) cyc(1, T5, 1'b1, 4'b0000, $sformatf("q4_pre_e%0d", n));
    clrn[1] = 1'b0;
    #1;
    chk("q4_clr_mid", obs(1), 4'b0000);
    clrn[1] = 1'b1;
    for (int n = 1; n <= 5; n++)
      cyc(1, T5, 1'b1, (n == 5) ? 4'b1001 : 4'b0000, $sformatf("q4_req_e%0d", n));
    // Asynchronous clear while qualified drops O and ANY without a clock edge.
    clrn[1] = 1'b0;
    #1;
    chk("q4_clr_async", obs(1), 4'b0000);
    clrn[1] = 1'b1;
    cyc(1, T5, 1'b1, 4'b0000, "q4_post_clr");
    cyc(1, Z5, 1'b1, 4'b0000, "q4_idle");

    // QUAL=3: true 2, false 1, true again -> O after 4 edges from restart.
    cyc(2, T5, 1'b1, 4'b0000, "q3_r_e1");
    cyc(2, T5, 1'b1, 4'b0000, "q3_r_e2");
    cyc(2, F5, 1'b1, 4'b0000, "q3_r_e3");
    for (int n = 4; n <= 7; n++)
      cyc(2, T5, 1'b1, (n == 7) ? 4'b1001 : 4'b0000, $sformatf("q3_r_e%0d", n));
    cyc(2, F5, 1'b1, 4'b1001, "q3_r_off1");
    cyc(2, F5, 1'b1, 4'b0000, "q3_r_off2");

    // QUAL=3: CE low for 5 cycles mid-run holds the count.
    cyc(2, T5, 1'b1, 4'b0000, "q3_ce_e1");
    cyc(2, T5, 1'b1, 4'b0000, "q3_ce_e2");
    for (int n = 0; n < 5; n++) cyc(2, T5, 1'b0, 4'b0000, $sformatf("q3_ce_hold%0d", n));
    cyc(2, T5, 1'b1, 4'b0000, "q3_ce_e3");
    cyc(2, T5, 1'b1, 4'b1001, "q3_ce_e4");
    // CE low also holds an asserted output against a false term.
    cyc(2, F5, 1'b0, 4'b1001, "q3_ce_holdhi0");
    cyc(2, F5, 1'b0, 4'b1001, "q3_ce_holdhi1");
    cyc(2, F5, 1'b1, 4'b1001, "q3_ce_off1");
    cyc(2, F5, 1'b1, 4'b0000, "q3_ce_off2");

    // Pulse mode, QUAL=2: one pulse at edge 3, a second after drop/re-assert.
    for (int n = 1; n <= 10; n++)
      cyc(3, T5, 1'b1, (n == 3) ? 4'b1001 : 4'b0000, $sformatf("pl_e%0d", n));
    cyc(3, F5, 1'b1, 4'b0000, "pl_drop");
    for (int n = 1; n <= 4; n++)
      cyc(3, T5, 1'b1, (n == 3) ? 4'b1001 : 4'b0000, $sformatf("pl_re_e%0d", n));

    // Three channels, mask 0101: ch0 and ch2 qualify together, ch1 never.
    cyc(4, 12'b1010_1111_1010, 1'b1, 4'b0000, "mc_e1");
    cyc(4, 12'b1010_1111_1010, 1'b1, 4'b0000, "mc_e2");
    cyc(4, 12'b1010_1111_1010, 1'b1, 4'b1101, "mc_e3");
    cyc(4, 12'b1010_1111_1010, 1'b1, 4'b1101, "mc_e4");
    cyc(4, 12'b1010_1111_0000, 1'b1, 4'b1101, "mc_drop0_a");
    cyc(4, 12'b0000_1111_0000, 1'b1, 4'b1100, "mc_drop0_b");
    cyc(4, 12'b0000_1111_0000, 1'b1, 4'b0000, "mc_drop2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
